// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard receiver.
//   PS2_FRAME_BITS / PS2_BYTE_W : frame and payload widths
//   scan_code_t                 : one scan-code byte
//   PS2_BREAK / PS2_EXT         : break and extended-prefix scan codes
//   odd_parity_ok / frame_ok    : frame checking helpers
package ps2_pkg;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_BYTE_W     = 8;

  typedef logic [PS2_BYTE_W-1:0] scan_code_t;

  localparam scan_code_t PS2_BREAK = 8'hF0;
  localparam scan_code_t PS2_EXT   = 8'hE0;

  // Odd parity holds when the data bits plus the parity bit XOR to 1.
  function automatic logic odd_parity_ok(input scan_code_t b, input logic p);
    return ((^b) ^ p) == 1'b1;
  endfunction

  // Frame layout, LSB first: [0] start, [8:1] data, [9] parity, [10] stop.
  function automatic logic frame_ok(input logic [PS2_FRAME_BITS-1:0] f);
    return (f[0] == 1'b0) && (f[10] == 1'b1) && odd_parity_ok(f[8:1], f[9]);
  endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// ps2_byte_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst : clock, asynchronous active-high reset
//   push, din: write request and data (accepted when not full, or when a
//              pop happens in the same cycle)
//   pop      : read request, ignored while empty
//   dout     : head entry, combinational read of the memory
//   full, empty : occupancy flags
module ps2_byte_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wptr_r;
  logic [AW:0]      rptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             do_pop_s;
  logic             do_push_s;

  // The extra pointer MSB separates full (MSBs differ) from empty (equal).
  assign empty     = (wptr_r == rptr_r);
  assign full      = (wptr_r[AW] != rptr_r[AW]) &&
                     (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
  assign do_pop_s  = pop & ~empty;
  // When full, a same-cycle pop frees the head slot the push lands in.
  assign do_push_s = push & (~full | do_pop_s);
  assign dout      = mem_r[rptr_r[AW-1:0]];

  // Read and write pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_r <= {(AW+1){1'b0}};
      rptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wptr_r <= wptr_r + PTR_ONE;
      if (do_pop_s)  rptr_r <= rptr_r + PTR_ONE;
    end
  end

  // Storage; cleared on reset so dout reads 0 before the first write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
    end else if (do_push_s) begin
      mem_r[wptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver front end.
//   clk, rst            : system clock, asynchronous active-high reset
//   ps2_clk, ps2_data   : raw asynchronous PS/2 pins
//   rd_en               : pop the head byte (ignored while valid=0)
//   clr_ovf             : clear the sticky overflow flag
//   data, valid         : FWFT head byte and not-empty flag
//   overflow            : sticky, a good byte was dropped on a full FIFO
//   frame_err           : one-cycle pulse on bad start/parity/stop
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 8192
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  input  logic       clr_ovf,
  output scan_code_t data,
  output logic       valid,
  output logic       overflow,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TCNT_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TCNT_ONE = TW'(1);

  logic [SYNC_STAGES-1:0]    clk_sync_r;
  logic [SYNC_STAGES-1:0]    dat_sync_r;
  logic                      clk_prev_r;
  logic                      fall_en_r;
  logic                      bit_r;
  logic [3:0]                bitcnt_r;
  logic [PS2_FRAME_BITS-1:0] shreg_r;
  logic [TW-1:0]             tcnt_r;
  logic                      frame_err_r;
  logic                      overflow_r;

  logic [PS2_FRAME_BITS-1:0] frame_next_s;
  logic                      frame_done_s;
  logic                      good_s;
  logic                      full_s;
  logic                      empty_s;
  logic                      ovf_event_s;

  // Pin synchronizers, preset to the idle-high bus level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_r <= {SYNC_STAGES{1'b1}};
      dat_sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      clk_sync_r <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
      dat_sync_r <= {dat_sync_r[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // Falling-edge strobe; the data bit is captured alongside so both align.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_prev_r <= 1'b1;
      fall_en_r  <= 1'b0;
      bit_r      <= 1'b1;
    end else begin
      clk_prev_r <= clk_sync_r[SYNC_STAGES-1];
      fall_en_r  <= clk_prev_r & ~clk_sync_r[SYNC_STAGES-1];
      bit_r      <= dat_sync_r[SYNC_STAGES-1];
    end
  end

  // Frame as it looks after the current bit is shifted in (LSB first).
  assign frame_next_s = {bit_r, shreg_r[PS2_FRAME_BITS-1:1]};
  assign frame_done_s = fall_en_r & (bitcnt_r == 4'd10);
  assign good_s       = frame_done_s & frame_ok(frame_next_s);
  assign ovf_event_s  = good_s & full_s & ~(rd_en & ~empty_s);

  // Deframer shift register, bit counter and inter-edge timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_r  <= {PS2_FRAME_BITS{1'b0}};
      bitcnt_r <= 4'd0;
      tcnt_r   <= {TW{1'b0}};
    end else if (fall_en_r) begin
      shreg_r  <= frame_next_s;
      bitcnt_r <= (bitcnt_r == 4'd10) ? 4'd0 : (bitcnt_r + 4'd1);
      tcnt_r   <= {TW{1'b0}};
    end else if (bitcnt_r != 4'd0) begin
      // A stalled partial frame is abandoned without flagging an error.
      if (tcnt_r == TCNT_MAX) begin
        bitcnt_r <= 4'd0;
        tcnt_r   <= {TW{1'b0}};
      end else begin
        tcnt_r   <= tcnt_r + TCNT_ONE;
      end
    end else begin
      tcnt_r <= {TW{1'b0}};
    end
  end

  // Error pulse and sticky overflow; a new overflow wins over clr_ovf.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      frame_err_r <= frame_done_s & ~frame_ok(frame_next_s);
      if (ovf_event_s) begin
        overflow_r <= 1'b1;
      end else if (clr_ovf) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  ps2_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PS2_BYTE_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (good_s),
    .din   (frame_next_s[8:1]),
    .pop   (rd_en),
    .dout  (data),
    .full  (full_s),
    .empty (empty_s)
  );

  assign valid     = ~empty_s;
  assign overflow  = overflow_r;
  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: directed self-checking bench for ps2_kbd_rx.
module tb_ps2_kbd_rx;

  localparam int TIMEOUT_CYCLES = 8192;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       overflow;
  logic       frame_err;

  int n_vec = 0;
  int n_err = 0;
  int ferr_cnt = 0;
  int ferr_base;
  logic [10:0] fr;

  ps2_kbd_rx #(
    .FIFO_DEPTH     (8),
    .SYNC_STAGES    (3),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rd_en     (rd_en),
    .clr_ovf   (clr_ovf),
    .data      (data),
    .valid     (valid),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Count every cycle in which frame_err is high.
  always @(negedge clk) if (frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;

  // Watchdog so the run always ends.
  initial begin
    #3ms;
    $display("FAIL watchdog: observed run still active, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 11-bit frame: stop, parity (odd, optionally corrupted), byte, start.
  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic flip);
    return {1'b1, (~^b) ^ flip, b, 1'b0};
  endfunction

  // Present a bit, then pull ps2_clk low; returns just after the fall.
  task automatic ps2_fall(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
  endtask

  task automatic ps2_rise();
    repeat (8) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_fall(f[i]);
      ps2_rise();
    end
  endtask

  task automatic pop1();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Good frame 8'h1C with latency check
    fr = mk_frame(8'h1C, 1'b0);
    chk("frame_1c_parity_bit", 32'(fr[9]), 32'd0);
    send_bits(fr, 10);
    ps2_fall(fr[10]);
    repeat (4) @(negedge clk);
    chk("lat_valid_at_4", 32'(valid), 32'd0);
    @(negedge clk);
    chk("lat_valid_at_5", 32'(valid), 32'd1);
    chk("lat_data_1c", 32'(data), 32'h1C);
    ps2_rise();
    pop1();
    chk("pop_1c_empty", 32'(valid), 32'd0);

    // Bad parity: one-cycle frame_err, nothing stored
    fr = mk_frame(8'h1C, 1'b1);
    send_bits(fr, 10);
    ps2_fall(fr[10]);
    repeat (4) @(negedge clk);
    chk("ferr_at_4", 32'(frame_err), 32'd0);
    @(negedge clk);
    chk("ferr_at_5", 32'(frame_err), 32'd1);
    @(negedge clk);
    chk("ferr_at_6", 32'(frame_err), 32'd0);
    ps2_rise();
    chk("ferr_valid", 32'(valid), 32'd0);

    // Nine frames with no reads: overflow on the ninth
    for (int i = 1; i <= 8; i++) send_bits(mk_frame(8'(i), 1'b0), 11);
    chk("fill8_overflow", 32'(overflow), 32'd0);
    send_bits(mk_frame(8'h09, 1'b0), 11);
    chk("ovf_set", 32'(overflow), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      chk("ovf_read_valid", 32'(valid), 32'd1);
      chk("ovf_read_data", 32'(data), 32'(i));
      pop1();
    end
    chk("ovf_drain_empty", 32'(valid), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    @(negedge clk);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Full FIFO, ninth frame completes together with a pop
    for (int i = 0; i < 8; i++) send_bits(mk_frame(8'h11 + 8'(i), 1'b0), 11);
    fr = mk_frame(8'h19, 1'b0);
    send_bits(fr, 10);
    ps2_fall(fr[10]);
    repeat (4) @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    chk("simul_overflow", 32'(overflow), 32'd0);
    ps2_rise();
    for (int i = 0; i < 8; i++) begin
      chk("simul_read_valid", 32'(valid), 32'd1);
      chk("simul_read_data", 32'(data), 32'h12 + 32'(i));
      pop1();
    end
    chk("simul_drain_empty", 32'(valid), 32'd0);
    chk("simul_overflow_end", 32'(overflow), 32'd0);

    // Partial frame abandoned by timeout
    ferr_base = ferr_cnt;
    send_bits(mk_frame(8'h5A, 1'b0), 5);
    repeat (TIMEOUT_CYCLES + 10) @(negedge clk);
    send_bits(mk_frame(8'hF0, 1'b0), 11);
    chk("tmo_valid", 32'(valid), 32'd1);
    chk("tmo_data", 32'(data), 32'hF0);
    pop1();
    chk("tmo_one_byte", 32'(valid), 32'd0);
    chk("tmo_no_ferr", 32'(ferr_cnt - ferr_base), 32'd0);

    // Partial frame abandoned by reset
    ferr_base = ferr_cnt;
    send_bits(mk_frame(8'h5A, 1'b0), 5);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_async_valid", 32'(valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send_bits(mk_frame(8'hF0, 1'b0), 11);
    chk("rstmid_valid", 32'(valid), 32'd1);
    chk("rstmid_data", 32'(data), 32'hF0);
    pop1();
    chk("rstmid_one_byte", 32'(valid), 32'd0);
    chk("rstmid_no_ferr", 32'(ferr_cnt - ferr_base), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
